// File: rtl/proc_feeder.sv
// proc_feeder: program memory plus instruction sequencer that feeds a simple
// multi-cycle processor one 9-bit word at a time (DIN/Run handshake, Done
// completion flag). Words are loaded while idle, then executed from address 0
// until a HALT marker (opcode 111) is issued.
//
// Optional build macro: FEEDER_WATCHDOG_EN
//   defined   -> a 3-bit watchdog forces HALT with Error=1 after 8 WAIT cycles
//                without Done.
//   undefined -> WAIT persists until Done; Error stays 0.
module proc_feeder #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [8:0]        LoadData,
    input  logic              Done,
    output logic [8:0]        DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [7:0]        InstrCount
);

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_IMM   = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // Completed-instruction counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [7:0]          icount_q, icount_d;
    logic                halted_q, halted_d;
    logic                error_q, error_d;
`ifdef FEEDER_WATCHDOG_EN
    logic [2:0]          wdog_q, wdog_d;
`endif

    logic [8:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   pc_plus1_s;
    logic [ADDR_W-1:0]   pc_plus2_s;
    logic [8:0]          cur_word_s;
    logic [8:0]          imm_word_s;
    logic [2:0]          opcode_s;
    logic                busy_s;
    logic [8:0]          din_s;
    logic                run_s;

    // Address arithmetic wraps naturally at ADDR_W bits (modulo DEPTH).
    assign pc_plus1_s = pc_q + ADDR_W'(1);
    assign pc_plus2_s = pc_q + ADDR_W'(2);
    assign cur_word_s = mem[pc_q];
    assign imm_word_s = mem[pc_plus1_s];
    assign opcode_s   = cur_word_s[8:6];
    assign busy_s     = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);

    // Program memory write port: loads only accepted while not executing; no reset.
    always_ff @(posedge Clock) begin
        if (LoadEn && !busy_s) begin
            mem[LoadAddr] <= LoadData;
        end
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        halted_d = halted_q;
        error_d  = error_q;
`ifdef FEEDER_WATCHDOG_EN
        wdog_d   = wdog_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    state_d  = S_ISSUE;
                    pc_d     = '0;
                    icount_d = 8'd0;
                    halted_d = 1'b0;
                    error_d  = 1'b0;
                end else begin
                    state_d  = state_q;
                end
            end
            S_ISSUE: begin
                if (opcode_s == OP_HALT) begin
                    // HALT marker is not an instruction: PC and count stay put.
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (opcode_s == OP_MVI) begin
                    state_d  = S_IMM;
                end else begin
                    state_d  = S_WAIT;
`ifdef FEEDER_WATCHDOG_EN
                    wdog_d   = 3'd0;
`endif
                end
            end
            S_IMM: begin
                // Immediate handed over; mvi needs no Done from the processor.
                state_d  = S_ISSUE;
                pc_d     = pc_plus2_s;
                icount_d = sat_inc(icount_q);
            end
            S_WAIT: begin
                if (Done) begin
                    state_d  = S_ISSUE;
                    pc_d     = pc_plus1_s;
                    icount_d = sat_inc(icount_q);
                end else begin
`ifdef FEEDER_WATCHDOG_EN
                    if (wdog_q == 3'd7) begin
                        // Eighth WAIT cycle with no Done: give up, keep PC for diagnosis.
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        error_d  = 1'b1;
                    end else begin
                        wdog_d   = wdog_q + 3'd1;
                    end
`else
                    state_d  = S_WAIT;
`endif
                end
            end
            default: begin
                state_d  = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            icount_q <= 8'd0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
`ifdef FEEDER_WATCHDOG_EN
            wdog_q   <= 3'd0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
            halted_q <= halted_d;
            error_q  <= error_d;
`ifdef FEEDER_WATCHDOG_EN
            wdog_q   <= wdog_d;
`endif
        end
    end

    // Processor-facing word and strobe, decoded from the registered state.
    always_comb begin
        din_s = 9'd0;
        run_s = 1'b0;
        case (state_q)
            S_ISSUE: begin
                din_s = cur_word_s;
                run_s = (opcode_s != OP_HALT);
            end
            S_IMM: begin
                din_s = imm_word_s;
                run_s = 1'b0;
            end
            default: begin
                din_s = 9'd0;
                run_s = 1'b0;
            end
        endcase
    end

    assign DIN        = din_s;
    assign Run        = run_s;
    assign PC         = pc_q;
    assign Busy       = busy_s;
    assign Halted     = halted_q;
    assign Error      = error_q;
    assign InstrCount = icount_q;

endmodule

// File: tb/tb_proc_feeder.sv
// Self-checking bench for proc_feeder: directed table of small programs,
// hand-written multi-cycle sequences, and randomized programs compared
// against a transaction-level execution model.
module tb_proc_feeder;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          Clock;
    logic          Resetn;
    logic          Start;
    logic          LoadEn;
    logic [AW-1:0] LoadAddr;
    logic [8:0]    LoadData;
    logic          Done;
    logic [8:0]    DIN;
    logic          Run;
    logic [AW-1:0] PC;
    logic          Busy;
    logic          Halted;
    logic          Error;
    logic [7:0]    InstrCount;

    int checks   = 0;
    int failures = 0;

    // Done source: either the responder (processor model) or the bench directly.
    logic proc_en;
    logic p_done;
    logic tb_done;
    int   p_rem;
    assign Done = proc_en ? p_done : tb_done;

    proc_feeder #(.DEPTH(DEPTH)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .LoadEn(LoadEn),
        .LoadAddr(LoadAddr), .LoadData(LoadData), .Done(Done), .DIN(DIN),
        .Run(Run), .PC(PC), .Busy(Busy), .Halted(Halted), .Error(Error),
        .InstrCount(InstrCount)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Processor latency: mv 1 cycle, add/sub 3, other single-word ops 2.
    function automatic int delay_of(input logic [2:0] op);
        if (op == 3'b000) return 1;
        else if (op == 3'b010 || op == 3'b011) return 3;
        else return 2;
    endfunction

    // Responder: raises Done in the last WAIT cycle of each issued instruction.
    always @(negedge Clock) begin
        if (!proc_en) begin
            p_rem  <= 0;
            p_done <= 1'b0;
        end else if (Run && DIN[8:6] != 3'b001) begin
            p_rem  <= delay_of(DIN[8:6]);
            p_done <= 1'b0;
        end else if (p_rem != 0) begin
            p_done <= (p_rem == 1);
            p_rem  <= p_rem - 1;
        end else begin
            p_done <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic load(input int addr, input logic [8:0] data);
        LoadEn   = 1'b1;
        LoadAddr = AW'(addr);
        LoadData = data;
        tick();
        LoadEn   = 1'b0;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        tick();
        tick();
        Resetn = 1'b1;
    endtask

    // Pulse Start; returns in cycle 1 (first ISSUE).
    task automatic start_run();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_halted();
        int n = 0;
        while (!Halted && n < 300) begin
            tick();
            n++;
        end
        chk("halt_reached", {31'd0, Halted}, 32'd1);
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        logic       done;
        logic [8:0] din;
        logic       run;
        int         pc;
        int         cnt;
        logic       busy;
        logic       halted;
    } trace_t;

    logic [8:0] ref_mem [DEPTH];
    trace_t     trace [$];

    function automatic trace_t mk(input logic d, input logic [8:0] w, input logic r,
                                  input int pc, input int cnt, input logic b, input logic h);
        trace_t t;
        t.done = d; t.din = w; t.run = r; t.pc = pc; t.cnt = cnt; t.busy = b; t.halted = h;
        return t;
    endfunction

    // Executes the program instruction by instruction, emitting per-cycle expectations.
    task automatic build_trace(input int max_cycles);
        int pc = 0;
        int cnt = 0;
        int d;
        logic [8:0] w;
        trace.delete();
        while (trace.size() < max_cycles) begin
            w = ref_mem[pc];
            if (w[8:6] == 3'b111) begin
                trace.push_back(mk(1'b0, w, 1'b0, pc, cnt, 1'b1, 1'b0));
                trace.push_back(mk(1'b0, 9'd0, 1'b0, pc, cnt, 1'b0, 1'b1));
                break;
            end else if (w[8:6] == 3'b001) begin
                trace.push_back(mk(1'b0, w, 1'b1, pc, cnt, 1'b1, 1'b0));
                trace.push_back(mk(1'b0, ref_mem[(pc + 1) % DEPTH], 1'b0, pc, cnt, 1'b1, 1'b0));
                pc  = (pc + 2) % DEPTH;
                cnt = (cnt < 255) ? cnt + 1 : 255;
            end else begin
                if (w[8:6] == 3'b000) d = 1;
                else if (w[8:6] == 3'b010 || w[8:6] == 3'b011) d = 3;
                else d = $urandom_range(1, 4);
                trace.push_back(mk(1'b0, w, 1'b1, pc, cnt, 1'b1, 1'b0));
                for (int k = 1; k <= d; k++)
                    trace.push_back(mk(k == d, 9'd0, 1'b0, pc, cnt, 1'b1, 1'b0));
                pc  = (pc + 1) % DEPTH;
                cnt = (cnt < 255) ? cnt + 1 : 255;
            end
        end
    endtask

    // ---------------- directed program table ----------------
    typedef struct {
        logic [8:0] w0, w1, w2, w3;
        int         exp_pc;
        int         exp_cnt;
    } dir_vec_t;

    dir_vec_t dv [7];

    initial begin
        Resetn = 1'b0; Start = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = 9'd0;
        tb_done = 1'b0; proc_en = 1'b0;

        dv[0] = '{9'h040, 9'h005, 9'h1C0, 9'h1C0, 2, 1};
        dv[1] = '{9'h081, 9'h1C0, 9'h1C0, 9'h1C0, 1, 1};
        dv[2] = '{9'h008, 9'h1C0, 9'h1C0, 9'h1C0, 1, 1};
        dv[3] = '{9'h1C0, 9'h000, 9'h000, 9'h000, 0, 0};
        dv[4] = '{9'h0C2, 9'h040, 9'h1C0, 9'h1C0, 3, 2};
        dv[5] = '{9'h100, 9'h1C0, 9'h1C0, 9'h1C0, 1, 1};
        dv[6] = '{9'h148, 9'h0D3, 9'h1C0, 9'h1C0, 2, 2};

        // Reset state.
        tick();
        chk("rst_pc", {27'd0, PC}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_run", {31'd0, Run}, 32'd0);
        chk("rst_din", {23'd0, DIN}, 32'd0);
        chk("rst_halted", {31'd0, Halted}, 32'd0);
        chk("rst_error", {31'd0, Error}, 32'd0);
        chk("rst_count", {24'd0, InstrCount}, 32'd0);
        Resetn = 1'b1;
        tick();

        // mvi followed by HALT, cycle by cycle.
        load(0, 9'h040); load(1, 9'h005); load(2, 9'h1C0);
        start_run();
        chk("mvi_c1_din", {23'd0, DIN}, 32'h040);
        chk("mvi_c1_run", {31'd0, Run}, 32'd1);
        tick();
        chk("mvi_c2_din", {23'd0, DIN}, 32'h005);
        chk("mvi_c2_run", {31'd0, Run}, 32'd0);
        tick();
        chk("mvi_c3_din", {23'd0, DIN}, 32'h1C0);
        chk("mvi_c3_run", {31'd0, Run}, 32'd0);
        tick();
        chk("mvi_halted", {31'd0, Halted}, 32'd1);
        chk("mvi_busy", {31'd0, Busy}, 32'd0);
        chk("mvi_pc", {27'd0, PC}, 32'd2);
        chk("mvi_count", {24'd0, InstrCount}, 32'd1);
        chk("mvi_halt_din", {23'd0, DIN}, 32'd0);

        // add with Done in the third WAIT cycle (restart straight from HALT).
        load(0, 9'h081); load(1, 9'h1C0);
        start_run();
        chk("add_c1_run", {31'd0, Run}, 32'd1);
        chk("add_c1_halted", {31'd0, Halted}, 32'd0);
        tick();
        chk("add_wait_din", {23'd0, DIN}, 32'd0);
        chk("add_wait_run", {31'd0, Run}, 32'd0);
        chk("add_wait_busy", {31'd0, Busy}, 32'd1);
        tick();
        tick();
        chk("add_w3_pc", {27'd0, PC}, 32'd0);
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        chk("add_pc_after_done", {27'd0, PC}, 32'd1);
        chk("add_count", {24'd0, InstrCount}, 32'd1);
        chk("add_halt_word", {23'd0, DIN}, 32'h1C0);
        tick();
        chk("add_halted", {31'd0, Halted}, 32'd1);
        chk("add_halt_count", {24'd0, InstrCount}, 32'd1);

        // Load and Start in the same idle cycle.
        do_reset();
        LoadEn = 1'b1; LoadAddr = '0; LoadData = 9'h1C0; Start = 1'b1;
        tick();
        LoadEn = 1'b0; Start = 1'b0;
        chk("ldst_din", {23'd0, DIN}, 32'h1C0);
        chk("ldst_run", {31'd0, Run}, 32'd0);
        tick();
        chk("ldst_halted", {31'd0, Halted}, 32'd1);

        // Directed program table with the responder supplying Done.
        proc_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            load(0, dv[i].w0); load(1, dv[i].w1); load(2, dv[i].w2); load(3, dv[i].w3);
            start_run();
            wait_halted();
            chk($sformatf("tbl%0d_pc", i), {27'd0, PC}, dv[i].exp_pc);
            chk($sformatf("tbl%0d_cnt", i), {24'd0, InstrCount}, dv[i].exp_cnt);
        end

        // mvi at the last address takes its immediate from address 0.
        load(0, 9'h007);
        for (int a = 1; a < 31; a++) load(a, 9'h000);
        load(31, 9'h040);
        start_run();
        repeat (62) tick();
        chk("wrap_issue_pc", {27'd0, PC}, 32'd31);
        chk("wrap_issue_din", {23'd0, DIN}, 32'h040);
        chk("wrap_issue_run", {31'd0, Run}, 32'd1);
        tick();
        chk("wrap_imm_din", {23'd0, DIN}, 32'h007);
        chk("wrap_imm_run", {31'd0, Run}, 32'd0);
        tick();
        chk("wrap_pc", {27'd0, PC}, 32'd1);
        chk("wrap_count", {24'd0, InstrCount}, 32'd32);

        // Counter saturation on an endless mv loop; Start mid-run is ignored.
        do_reset();
        for (int a = 0; a < DEPTH; a++) load(a, 9'h000);
        start_run();
        for (int c = 1; c < 601; c++) begin
            Start = (c == 101);
            if (c == 401) begin
                chk("sat_mid_count", {24'd0, InstrCount}, 32'd200);
                chk("sat_mid_pc", {27'd0, PC}, 32'd8);
            end
            tick();
        end
        Start = 1'b0;
        chk("sat_count", {24'd0, InstrCount}, 32'd255);
        chk("sat_busy", {31'd0, Busy}, 32'd1);

        // Asynchronous reset during WAIT, then re-run.
        proc_en = 1'b0;
        do_reset();
        load(0, 9'h081); load(1, 9'h1C0);
        start_run();
        tick();
        tick();
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst_run", {31'd0, Run}, 32'd0);
        chk("arst_busy", {31'd0, Busy}, 32'd0);
        chk("arst_pc", {27'd0, PC}, 32'd0);
        chk("arst_din", {23'd0, DIN}, 32'd0);
        tick();
        Resetn = 1'b1;
        proc_en = 1'b1;
        start_run();
        chk("arst_rerun_din", {23'd0, DIN}, 32'h081);
        wait_halted();
        chk("arst_rerun_pc", {27'd0, PC}, 32'd1);
        chk("arst_rerun_cnt", {24'd0, InstrCount}, 32'd1);

        // Done never arrives.
        proc_en = 1'b0;
        start_run();
`ifdef FEEDER_WATCHDOG_EN
        repeat (8) tick();
        chk("wd_busy_c9", {31'd0, Busy}, 32'd1);
        tick();
        chk("wd_error", {31'd0, Error}, 32'd1);
        chk("wd_halted", {31'd0, Halted}, 32'd1);
        chk("wd_pc", {27'd0, PC}, 32'd0);
`else
        begin
            int busy_cycles = 0;
            int err_cycles  = 0;
            for (int c = 0; c < 50; c++) begin
                tick();
                if (Busy) busy_cycles++;
                if (Error) err_cycles++;
            end
            chk("nowd_busy_cycles", busy_cycles, 32'd50);
            chk("nowd_error_cycles", err_cycles, 32'd0);
        end
`endif

        // Load attempt while busy must not alter memory.
        do_reset();
        start_run();
        tick();
        LoadEn = 1'b1; LoadAddr = '0; LoadData = 9'h1FF;
        tick();
        LoadEn = 1'b0;
        do_reset();
        start_run();
        chk("busy_load_ignored", {23'd0, DIN}, 32'h081);

        // Randomized programs against the execution model.
        proc_en = 1'b0;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int a = 0; a < DEPTH; a++) begin
                ref_mem[a] = 9'($urandom_range(0, 511));
                load(a, ref_mem[a]);
            end
            build_trace(150);
            start_run();
            for (int i = 0; i < trace.size(); i++) begin
                chk($sformatf("rnd%0d_din@%0d", it, i), {23'd0, DIN}, {23'd0, trace[i].din});
                chk($sformatf("rnd%0d_run@%0d", it, i), {31'd0, Run}, {31'd0, trace[i].run});
                chk($sformatf("rnd%0d_pc@%0d", it, i), {27'd0, PC}, trace[i].pc);
                chk($sformatf("rnd%0d_cnt@%0d", it, i), {24'd0, InstrCount}, trace[i].cnt);
                chk($sformatf("rnd%0d_busy@%0d", it, i), {31'd0, Busy}, {31'd0, trace[i].busy});
                chk($sformatf("rnd%0d_halt@%0d", it, i), {31'd0, Halted}, {31'd0, trace[i].halted});
                chk($sformatf("rnd%0d_err@%0d", it, i), {31'd0, Error}, 32'd0);
                tb_done = trace[i].done;
                tick();
                tb_done = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
